conv_avg: RTL and testbench

Averaging converter that sits directly upstream of the pulse-length stage and answers its soc/eoc handshake. On each start-of-conversion it collects NSAMP valid 8-bit samples, computes their truncated mean, clamps it to a minimum, and presents it on `numero` with `eoc` high. The downstream stage uses that value as a count length. The clamp keeps a zero result from making that count wrap.

---
 rtl/conv_pkg.sv | 16 +
 rtl/sample_acc.sv | 48 ++++
 rtl/conv_avg.sv | 77 +++++++
 tb/tb_conv_avg.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the averaging converter: sample width, FSM encoding
// and the accumulator width helper.
package conv_pkg;

    localparam int W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACK  = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;

    // Worst-case sum NSAMP*255 fits in W+log2(NSAMP) bits.
    function automatic int acc_width(input int nsamp);
        return W + $clog2(nsamp);
    endfunction

endpackage

// File: rtl/sample_acc.sv
// Sample accumulator: running sum and sample count for one conversion.
// next_sum already includes the sample being presented this cycle.
module sample_acc
    import conv_pkg::*;
#(
    parameter int NSAMP = 4,
    localparam int AW = acc_width(NSAMP)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [W-1:0]  sample,
    output logic          last,
    output logic [AW-1:0] next_sum
);

    localparam int CW = (NSAMP > 1) ? $clog2(NSAMP) : 1;

    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign next_sum = acc_q + AW'(sample);
    assign last     = (cnt_q == CW'(NSAMP - 1));

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (enable) begin
            acc_d = next_sum;
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_avg.sv
// Averaging converter answering a 4-phase soc/eoc handshake; outputs the
// truncated mean of NSAMP samples, clamped from below to MIN_OUT.
module conv_avg
    import conv_pkg::*;
#(
    parameter int NSAMP   = 4,
    parameter int MIN_OUT = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         soc,
    input  logic [W-1:0] sample,
    input  logic         sample_valid,
    output logic         eoc,
    output logic [W-1:0] numero
);

    localparam int LOG = $clog2(NSAMP);
    localparam int AW  = acc_width(NSAMP);
    localparam logic [W-1:0] MIN_V = W'(MIN_OUT);

    logic [1:0]    state_q, state_d;
    logic          eoc_q, eoc_d;
    logic [W-1:0]  numero_q, numero_d;
    logic          clear, enable, last, done;
    logic [AW-1:0] next_sum;
    logic [W-1:0]  mean, clamped;

    assign clear   = (state_q == ACK) && !soc;
    assign enable  = (state_q == ACC) && sample_valid;
    assign done    = enable && last;
    assign mean    = W'(next_sum >> LOG);
    assign clamped = (mean < MIN_V) ? MIN_V : mean;

    sample_acc #(.NSAMP(NSAMP)) u_acc (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .enable   (enable),
        .sample   (sample),
        .last     (last),
        .next_sum (next_sum)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            eoc_q    <= 1'b1;
            numero_q <= MIN_V;
        end else begin
            state_q  <= state_d;
            eoc_q    <= eoc_d;
            numero_q <= numero_d;
        end
    end

    // soc seen in ACC is a protocol violation and is deliberately ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (soc)  state_d = ACK;
            ACK:     if (!soc) state_d = ACC;
            ACC:     if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eoc_d    = (state_d == IDLE);
        numero_d = numero_q;
        if (done) numero_d = clamped;
    end

    assign eoc    = eoc_q;
    assign numero = numero_q;

endmodule

// File: tb/tb_conv_avg.sv
// Directed bench for conv_avg: a 4-sample/clamp-1 build and a
// 1-sample/clamp-0 build, checked through per-build expected-result queues.
module tb_conv_avg;

    logic       clock = 1'b0;
    logic       reset, soc, sample_valid, eoc;
    logic [7:0] sample, numero;
    logic       soc1, valid1, eoc1;
    logic [7:0] sample1, numero1;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q1[$];
    logic [7:0] model_numero;

    always #5 clock = ~clock;

    conv_avg #(.NSAMP(4), .MIN_OUT(1)) u_dut (
        .clock(clock), .reset(reset), .soc(soc), .sample(sample),
        .sample_valid(sample_valid), .eoc(eoc), .numero(numero)
    );

    conv_avg #(.NSAMP(1), .MIN_OUT(0)) u_dut1 (
        .clock(clock), .reset(reset), .soc(soc1), .sample(sample1),
        .sample_valid(valid1), .eoc(eoc1), .numero(numero1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop an expected result on every eoc rise not caused by reset.
    logic eoc_prev = 1'b1, eoc1_prev = 1'b1;
    always @(posedge clock) begin
        logic r;
        r = reset;
        #2;
        if (eoc && !eoc_prev && !r) begin
            if (exp_q.size() == 0) check("sb0_unexpected_eoc", 1, 0);
            else check("sb0_numero", numero, exp_q.pop_front());
        end
        if (eoc1 && !eoc1_prev && !r) begin
            if (exp_q1.size() == 0) check("sb1_unexpected_eoc", 1, 0);
            else check("sb1_numero", numero1, exp_q1.pop_front());
        end
        eoc_prev  = eoc;
        eoc1_prev = eoc1;
    end

    task automatic start_conv();
        soc = 1'b1;
        @(negedge clock);
        check("ack_eoc_low", eoc, 0);
    endtask

    // Called at a negedge with the DUT in ACK; drops soc and feeds 4 samples.
    task automatic run_conv(input logic [7:0] s0, s1, s2, s3, input logic [7:0] exp_num,
                            input int stall_at, input int stall_len, input int pulse_at,
                            input bit hold_end, input int exp_lat);
        logic [7:0] s[4];
        int idx, stalled, cyc;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        exp_q.push_back(exp_num);
        soc = 1'b0;
        @(negedge clock);
        cyc = 0; idx = 0; stalled = 0;
        while (cyc < 60) begin
            if ((idx == stall_at && stalled < stall_len) || idx >= 4) begin
                sample_valid = 1'b0;
                sample = 8'($urandom_range(0, 255));
                stalled++;
            end else begin
                sample_valid = 1'b1;
                sample = s[idx];
                idx++;
            end
            soc = (cyc == pulse_at) || (hold_end && idx == 4);
            @(negedge clock);
            cyc++;
            if (eoc) break;
            check("numero_stable", numero, model_numero);
        end
        sample_valid = 1'b0;
        check("latency", cyc, exp_lat);
        model_numero = exp_num;
    endtask

    task automatic conv1(input logic [7:0] s, input logic [7:0] exp_num);
        int cyc;
        soc1 = 1'b1;
        @(negedge clock);
        check("dut1_ack_eoc_low", eoc1, 0);
        soc1 = 1'b0;
        exp_q1.push_back(exp_num);
        @(negedge clock);
        cyc = 0;
        while (cyc < 20) begin
            valid1 = 1'b1;
            sample1 = s;
            @(negedge clock);
            cyc++;
            if (eoc1) break;
        end
        valid1 = 1'b0;
        check("dut1_latency", cyc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; soc = 1'b0; sample = 8'd0; sample_valid = 1'b0;
        soc1 = 1'b0; sample1 = 8'd0; valid1 = 1'b0;
        model_numero = 8'd1;
        @(negedge clock);
        @(negedge clock);
        check("reset_eoc", eoc, 1);
        check("reset_numero", numero, 1);
        check("dut1_reset_numero", numero1, 0);
        reset = 1'b0;

        // Idle with valid samples present: nothing may change.
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1'b1;
            sample = 8'($urandom_range(0, 255));
            @(negedge clock);
            check("idle_eoc", eoc, 1);
            check("idle_numero", numero, 1);
        end
        sample_valid = 1'b0;

        start_conv();
        run_conv(8'd10, 8'd20, 8'd30, 8'd41, 8'd25, -1, 0, -1, 1'b0, 4);

        start_conv();
        run_conv(8'd0, 8'd0, 8'd1, 8'd2, 8'd1, 2, 3, -1, 1'b0, 7);

        start_conv();
        run_conv(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, -1, 0, -1, 1'b1, 4);
        @(negedge clock);
        check("b2b_eoc_low", eoc, 0);
        check("b2b_numero_held", numero, 255);
        run_conv(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, -1, 0, -1, 1'b0, 4);

        start_conv();
        run_conv(8'd10, 8'd20, 8'd30, 8'd41, 8'd25, -1, 0, 1, 1'b0, 4);

        // Abort a conversion halfway with reset.
        start_conv();
        soc = 1'b0;
        @(negedge clock);
        sample_valid = 1'b1; sample = 8'd50;
        @(negedge clock);
        sample = 8'd60;
        @(negedge clock);
        check("midop_eoc_low", eoc, 0);
        reset = 1'b1; sample_valid = 1'b0;
        @(negedge clock);
        check("midop_reset_eoc", eoc, 1);
        check("midop_reset_numero", numero, 1);
        reset = 1'b0;
        model_numero = 8'd1;

        start_conv();
        run_conv(8'd8, 8'd8, 8'd8, 8'd8, 8'd8, -1, 0, -1, 1'b0, 4);

        conv1(8'd0, 8'd0);
        conv1(8'd200, 8'd200);

        repeat (4) @(negedge clock);
        check("sb0_queue_empty", exp_q.size(), 0);
        check("sb1_queue_empty", exp_q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
